// File: rtl/pwm_pkg.sv
// Shared constants and FSM state type for the PWM capture block.
package pwm_pkg;

   localparam int unsigned DUTY_W    = 10;
   localparam int unsigned CNT_W_DEF = 20;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Serial restoring divider: q = min(floor({num,10'b0} / den), 1023), one quotient bit per cycle.
// Used by pwm_capture only when PWM_CAPTURE_DUTY_EN is defined.
module pwm_duty_div
   import pwm_pkg::*;
#(
   parameter int unsigned N = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N-1:0]      num,
   input  logic [N-1:0]      den,
   output logic              busy,
   output logic              done,
   output logic [DUTY_W-1:0] q
);

   localparam int unsigned W      = N + DUTY_W;
   localparam int unsigned STEP_W = $clog2(W + 1);

   logic [N-1:0]      den_q;
   logic [N-1:0]      rem_q;
   logic [W-1:0]      quo_q;
   logic [STEP_W-1:0] step_q;

   logic [N:0]        shifted;
   logic [N:0]        diff;
   logic              ge;
   logic [N-1:0]      rem_d;
   logic [W-1:0]      quo_d;

   // quo_q shifts dividend bits out at the top while quotient bits enter at the bottom
   always_comb begin
      shifted = {rem_q, quo_q[W-1]};
      diff    = shifted - {1'b0, den_q};
      ge      = (shifted >= {1'b0, den_q});
      rem_d   = ge ? diff[N-1:0] : shifted[N-1:0];
      quo_d   = {quo_q[W-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         den_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         step_q <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         q      <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            den_q  <= den;
            rem_q  <= '0;
            quo_q  <= {num, {DUTY_W{1'b0}}};
            step_q <= '0;
            busy   <= 1'b1;
         end else if (busy) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            step_q <= step_q + 1'b1;
            if (step_q == STEP_W'(W - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
               q    <= (|quo_d[W-1:DUTY_W]) ? '1 : quo_d[DUTY_W-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: high time and period in clk cycles, stuck detection, optional 10-bit duty.
// Define PWM_CAPTURE_DUTY_EN to build the duty divider; otherwise duty_q10/duty_valid are tied to 0.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_in,
   output logic              level,
   output logic [CNT_W-1:0]  high_cnt,
   output logic [CNT_W-1:0]  period_cnt,
   output logic              meas_valid,
   output logic              stuck,
   output logic [DUTY_W-1:0] duty_q10,
   output logic              duty_valid
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] fill_q;
   logic                   prev_q;
   logic                   armed_q;
   logic                   rise;
   logic                   fall;

   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       hi_snap_q;

   logic                   cnt_restart;
   logic                   take_snap;
   logic                   publish;
   logic                   set_stuck;
   logic                   clr_stuck;

   // fill_q marks when level reflects a real post-reset sample; armed_q needs a genuine low
   // so an input already high out of reset is not taken as a rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         fill_q  <= '0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         prev_q <= sync_q[SYNC_STAGES-1];
         if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1])
            armed_q <= 1'b1;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      cnt_restart = 1'b0;
      take_snap   = 1'b0;
      publish     = 1'b0;
      set_stuck   = 1'b0;
      clr_stuck   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise && armed_q) begin
               state_d     = HIGH;
               cnt_restart = 1'b1;
               clr_stuck   = 1'b1;
            end
         end
         HIGH: begin
            if (fall) begin
               state_d   = LOW;
               take_snap = 1'b1;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = IDLE;
               set_stuck = 1'b1;
            end
         end
         LOW: begin
            if (rise) begin
               state_d     = HIGH;
               cnt_restart = 1'b1;
               publish     = 1'b1;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = IDLE;
               set_stuck = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Counter is 1 on the cycle after the rise, so at the fall/next rise it equals cycles since the rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         hi_snap_q  <= '0;
         high_cnt   <= '0;
         period_cnt <= '0;
         meas_valid <= 1'b0;
         stuck      <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (cnt_restart)
            cnt_q <= CNT_W'(1);
         else if (state_q != IDLE && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
         if (take_snap)
            hi_snap_q <= cnt_q;
         if (publish) begin
            high_cnt   <= hi_snap_q;
            period_cnt <= cnt_q;
            meas_valid <= 1'b1;
         end
         if (set_stuck)
            stuck <= 1'b1;
         else if (clr_stuck)
            stuck <= 1'b0;
      end
   end

`ifdef PWM_CAPTURE_DUTY_EN
   logic              div_busy;
   logic              div_done;
   logic [DUTY_W-1:0] div_q;

   pwm_duty_div #(
      .N(CNT_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (meas_valid),
      .num   (high_cnt),
      .den   (period_cnt),
      .busy  (div_busy),
      .done  (div_done),
      .q     (div_q)
   );

   assign duty_q10   = div_q;
   assign duty_valid = div_done & ~div_busy;
`else
   assign duty_q10   = '0;
   assign duty_valid = 1'b0;
`endif

endmodule
